// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between fetch and load/store; one transaction outstanding.
// Grant is combinational in IDLE (response passes straight through); a held request waits on bus_gnt_i.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned XLEN         = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  input  logic            if_flush_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            dm_req_i,
  input  logic            dm_we_i,
  input  logic [3:0]      dm_be_i,
  input  logic [XLEN-1:0] dm_addr_i,
  input  logic [XLEN-1:0] dm_wdata_i,
  output logic            dm_gnt_o,
  output logic            dm_rvalid_o,
  output logic [XLEN-1:0] dm_rdata_o,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [3:0]      bus_be_o,
  output logic [XLEN-1:0] bus_addr_o,
  output logic [XLEN-1:0] bus_wdata_o,
  input  logic            bus_gnt_i,
  input  logic            bus_rvalid_i,
  input  logic [XLEN-1:0] bus_rdata_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_I = 2'd1, WAIT_D = 2'd2} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       discard, discard_nxt;
  logic       sel_d, sel_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      discard    <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      discard    <= discard_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    starve_nxt  = starve_cnt;
    discard_nxt = discard;
    sel_d       = 1'b0;
    sel_i       = 1'b0;
    if_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    dm_gnt_o    = 1'b0;
    dm_rvalid_o = 1'b0;
    dm_rdata_o  = '0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_be_o    = 4'h0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;

    case (state)
      IDLE: begin
        sel_d     = dm_req_i & (~if_req_i | (starve_cnt < LIMIT));
        sel_i     = if_req_i & ~sel_d;
        bus_req_o = sel_d | sel_i;
        if (sel_d) begin
          bus_we_o    = dm_we_i;
          bus_be_o    = dm_be_i;
          bus_addr_o  = dm_addr_i;
          bus_wdata_o = dm_wdata_i;
        end else if (sel_i) begin
          bus_be_o   = 4'hF;
          bus_addr_o = if_addr_i;
        end
        if_gnt_o = sel_i & bus_gnt_i;
        dm_gnt_o = sel_d & bus_gnt_i;
        if (dm_gnt_o) state_nxt = WAIT_D;
        if (if_gnt_o) state_nxt = WAIT_I;
        // A flush in the grant cycle already makes the coming response stale.
        discard_nxt = if_gnt_o & if_flush_i;
      end
      WAIT_I: begin
        if (bus_rvalid_i) begin
          if_rvalid_o = ~discard & ~if_flush_i;
          if_rdata_o  = if_rvalid_o ? bus_rdata_i : '0;
          state_nxt   = IDLE;
          discard_nxt = 1'b0;
        end else begin
          discard_nxt = discard | if_flush_i;
        end
      end
      WAIT_D: begin
        if (bus_rvalid_i) begin
          dm_rvalid_o = 1'b1;
          dm_rdata_o  = bus_rdata_i;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (~if_req_i | if_gnt_o) begin
      starve_nxt = 4'd0;
    end else if (dm_gnt_o && (starve_cnt < LIMIT)) begin
      starve_nxt = starve_cnt + 4'd1;
    end

    // Outputs stay quiet for the whole reset cycle, whatever the requesters do.
    if (rst_i) begin
      if_gnt_o    = 1'b0;
      if_rvalid_o = 1'b0;
      if_rdata_o  = '0;
      dm_gnt_o    = 1'b0;
      dm_rvalid_o = 1'b0;
      dm_rdata_o  = '0;
      bus_req_o   = 1'b0;
      bus_we_o    = 1'b0;
      bus_be_o    = 4'h0;
      bus_addr_o  = '0;
      bus_wdata_o = '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus multi-cycle corner sequences.
module tb_mem_port_arbiter;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT_D = 2'd2;

  typedef struct packed {
    logic        rst, if_req;
    logic [31:0] if_addr;
    logic        if_flush, dm_req, dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;
  } in_t;

  typedef struct packed {
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        bus_req, bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr, bus_wdata;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t  s;
  out_t o;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, bus_req, bus_we;
  logic [31:0] if_rdata, dm_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [1:0]  st;

  assign o  = {if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               bus_req, bus_we, bus_be, bus_addr, bus_wdata};
  assign st = dut.state;

  mem_port_arbiter #(.STARVE_LIMIT(3), .XLEN(32)) dut (
    .clk_i(clk), .rst_i(s.rst),
    .if_req_i(s.if_req), .if_addr_i(s.if_addr), .if_flush_i(s.if_flush),
    .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .dm_req_i(s.dm_req), .dm_we_i(s.dm_we), .dm_be_i(s.dm_be),
    .dm_addr_i(s.dm_addr), .dm_wdata_i(s.dm_wdata),
    .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_be_o(bus_be),
    .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
    .bus_gnt_i(s.bus_gnt), .bus_rvalid_i(s.bus_rvalid), .bus_rdata_i(s.bus_rdata)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_o(input string nm, input out_t act, input out_t exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic in_t iv(bit rst, bit ir, logic [31:0] ia, bit fl, bit dr, bit we,
                             logic [3:0] be, logic [31:0] da, logic [31:0] wd,
                             bit g, bit rv, logic [31:0] rd);
    return {rst, ir, ia, fl, dr, we, be, da, wd, g, rv, rd};
  endfunction

  function automatic out_t ov(bit ig, bit irv, logic [31:0] ird, bit dg, bit drv,
                              logic [31:0] drd, bit br, bit bwe, logic [3:0] bbe,
                              logic [31:0] ba, logic [31:0] bwd);
    return {ig, irv, ird, dg, drv, drd, br, bwe, bbe, ba, bwd};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  out_t zero_o;
  bit   ei;
  int   exp_cnt;

  initial begin
    zero_o = '0;
    s      = '0;
    //                    rst ir ia      fl dr we be    da       wd            g  rv rd
    tbl.push_back('{"rst_busy",      iv(1,1,'h100,0,1,1,'hF,'h2000,'h5,1,1,'h9),                       zero_o});
    tbl.push_back('{"rst_idle",      iv(1,0,0,0,0,0,0,0,0,0,0,0),                                      zero_o});
    tbl.push_back('{"fetch_gnt",     iv(0,1,'h100,0,0,0,0,0,0,1,0,0),                                  ov(1,0,0,0,0,0,1,0,'hF,'h100,0)});
    tbl.push_back('{"fetch_rsp",     iv(0,0,0,0,0,0,0,0,0,0,1,'h13),                                   ov(0,1,'h13,0,0,0,0,0,0,0,0)});
    tbl.push_back('{"idle_rvalid",   iv(0,0,0,0,0,0,0,0,0,0,1,'h55),                                   zero_o});
    tbl.push_back('{"store_gnt",     iv(0,0,0,0,1,1,'h3,'h2004,'hDEADBEEF,1,0,0),                      ov(0,0,0,1,0,0,1,1,'h3,'h2004,'hDEADBEEF)});
    tbl.push_back('{"store_rsp",     iv(0,1,'h104,0,0,0,0,0,0,1,1,0),                                  ov(0,0,0,0,1,0,0,0,0,0,0)});
    tbl.push_back('{"fetch_nogrant", iv(0,1,'h104,0,0,0,0,0,0,0,0,0),                                  ov(0,0,0,0,0,0,1,0,'hF,'h104,0)});
    tbl.push_back('{"load_wins",     iv(0,1,'h104,0,1,0,'hF,'h3000,'h11111111,1,0,0),                  ov(0,0,0,1,0,0,1,0,'hF,'h3000,'h11111111)});
    tbl.push_back('{"load_rsp_fl",   iv(0,1,'h104,1,0,0,0,0,0,0,1,'hCAFE0001),                         ov(0,0,0,0,1,'hCAFE0001,0,0,0,0,0)});
    tbl.push_back('{"fetch_after",   iv(0,1,'h104,0,0,0,0,0,0,1,0,0),                                  ov(1,0,0,0,0,0,1,0,'hF,'h104,0)});
    tbl.push_back('{"fetch_rsp2",    iv(0,0,0,0,0,0,0,0,0,0,1,'h00A00093),                             ov(0,1,'h00A00093,0,0,0,0,0,0,0,0)});
    tbl.push_back('{"flush_at_gnt",  iv(0,1,'h108,1,0,0,0,0,0,1,0,0),                                  ov(1,0,0,0,0,0,1,0,'hF,'h108,0)});
    tbl.push_back('{"flushed_rsp",   iv(0,0,0,0,0,0,0,0,0,0,1,'h77),                                   zero_o});
    tbl.push_back('{"idle_flush",    iv(0,1,'h10C,1,0,0,0,0,0,0,0,0),                                  ov(0,0,0,0,0,0,1,0,'hF,'h10C,0)});
    tbl.push_back('{"fetch_gnt3",    iv(0,1,'h10C,0,0,0,0,0,0,1,0,0),                                  ov(1,0,0,0,0,0,1,0,'hF,'h10C,0)});
    tbl.push_back('{"fetch_rsp3",    iv(0,0,0,0,0,0,0,0,0,0,1,'h99),                                   ov(0,1,'h99,0,0,0,0,0,0,0,0)});

    #1;
    foreach (tbl[k]) begin
      s = tbl[k].i;
      @(negedge clk);
      chk_o(tbl[k].name, o, tbl[k].o);
      next_cycle();
    end
    chk("starve_idle", 64'(dut.starve_cnt), 64'd0);

    // Contention with a 1-cycle memory: D, D, D, I repeating.
    for (int k = 0; k < 8; k++) begin
      ei = ((k % 4) == 3);
      exp_cnt = ei ? 0 : (k % 4) + 1;
      s = iv(0,1,'h400,0,1,0,'hF,'h500,0,1,0,0);
      @(negedge clk);
      chk($sformatf("cont_gnt%0d", k), 64'({if_gnt, dm_gnt}), 64'({ei, ~ei}));
      next_cycle();
      chk($sformatf("cont_starve%0d", k), 64'(dut.starve_cnt), 64'(exp_cnt));
      s.bus_rvalid = 1'b1;
      s.bus_rdata  = 32'(k);
      @(negedge clk);
      chk($sformatf("cont_rsp%0d", k), 64'({if_rvalid, dm_rvalid}), 64'({ei, ~ei}));
      next_cycle();
    end

    // Flush while the fetch to 0x200 is in flight; response arrives 3 cycles later.
    s = iv(0,1,'h200,0,0,0,0,0,0,1,0,0);
    @(negedge clk);
    chk("fl_gnt", 64'(if_gnt), 64'd1);
    next_cycle();
    s = iv(0,0,0,1,0,0,0,0,0,0,0,0);
    @(negedge clk);
    chk("fl_pulse", 64'({if_rvalid, if_rdata}), 64'd0);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      s = iv(0,0,0,0,0,0,0,0,0,0,0,0);
      @(negedge clk);
      chk($sformatf("fl_wait%0d", k), 64'({if_rvalid, if_rdata}), 64'd0);
      next_cycle();
    end
    s = iv(0,0,0,0,0,0,0,0,0,0,1,'hBAD);
    @(negedge clk);
    chk("fl_stale_rsp", 64'({if_rvalid, if_rdata}), 64'd0);
    next_cycle();
    s = iv(0,1,'h300,0,0,0,0,0,0,1,0,0);
    @(negedge clk);
    chk("fl_next_gnt", 64'({if_gnt, bus_addr}), 64'({1'b1, 32'h300}));
    next_cycle();
    s = iv(0,0,0,0,0,0,0,0,0,0,1,'h600);
    @(negedge clk);
    chk("fl_next_rsp", 64'({if_rvalid, if_rdata}), 64'({1'b1, 32'h600}));
    next_cycle();

    // Backpressure: data request held against bus_gnt_i = 0, fetch also pending.
    for (int k = 0; k < 4; k++) begin
      s = iv(0,1,'h700,0,1,0,'hF,'h800,0,0,0,0);
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k), 64'({dm_gnt, if_gnt, bus_req, bus_addr}), 64'({3'b001, 32'h800}));
      chk($sformatf("bp_state%0d", k), 64'(st), 64'(ST_IDLE));
      next_cycle();
    end
    s.bus_gnt = 1'b1;
    @(negedge clk);
    chk("bp_gnt", 64'({dm_gnt, if_gnt, bus_req}), 64'(3'b101));
    next_cycle();
    chk("bp_wait_d", 64'(st), 64'(ST_WAIT_D));
    chk("bp_starve", 64'(dut.starve_cnt), 64'd1);

    // Reset while in WAIT_D, then a late response.
    s.rst = 1'b1;
    @(negedge clk);
    chk_o("rst_mid_outs", o, zero_o);
    next_cycle();
    s = iv(0,0,0,0,0,0,0,0,0,0,1,'h1234);
    @(negedge clk);
    chk_o("late_rsp_outs", o, zero_o);
    chk("late_rsp_starve", 64'(dut.starve_cnt), 64'd0);
    chk("late_rsp_state", 64'(st), 64'(ST_IDLE));
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory bus between the instruction-fetch port (IF) and the load/store port (MEM stage) of the 5-stage core.
- Allows one outstanding transaction at a time.
- Data requests normally win arbitration; a starvation counter guarantees forward progress for fetch.
- A fetch flush (branch, jump or trap redirect) discards the response of an in-flight fetch so that stale instructions never reach IF/ID.

Parameters:
STARVE_LIMIT, 3, max consecutive data grants while a fetch is pending before fetch is forced to win (1..15)
XLEN, 32, address/data width

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
if_req_i  input  1  fetch request, held until if_gnt_o
if_addr_i  input  XLEN  fetch address
if_flush_i  input  1  kill current/in-flight fetch
if_gnt_o  output  1  fetch request accepted by bus this cycle
if_rvalid_o  output  1  fetch data valid
if_rdata_o  output  XLEN  fetched instruction
dm_req_i  input  1  data request, held until dm_gnt_o
dm_we_i  input  1  1 = store, 0 = load
dm_be_i  input  4  byte enables
dm_addr_i  input  XLEN  data address
dm_wdata_i  input  XLEN  store data
dm_gnt_o  output  1  data request accepted
dm_rvalid_o  output  1  load data valid / store complete
dm_rdata_o  output  XLEN  load data
bus_req_o  output  1  request to memory
bus_we_o  output  1  write enable
bus_be_o  output  4  byte enables (4'hF for fetch)
bus_addr_o  output  XLEN  address
bus_wdata_o  output  XLEN  write data (0 for fetch)
bus_gnt_i  input  1  memory accepts request
bus_rvalid_i  input  1  response valid; asserted for both reads and writes
bus_rdata_i  input  XLEN  read data

Behaviour:
- FSM states: IDLE, WAIT_I, WAIT_D. Reset → IDLE; starve_cnt = 0; discard = 0.
- On reset, all outputs are 0: no bus_req_o, no gnt, no rvalid, and data outputs are 0.
- IDLE selection (combinational):
  - sel_d = dm_req_i & (~if_req_i | starve_cnt < STARVE_LIMIT).
  - sel_i = if_req_i & ~sel_d.
- IDLE bus drive:
  - bus_req_o = sel_d | sel_i; bus fields are driven from the selected port.
  - Unselected fields are 0.
- Grant:
  - if_gnt_o = sel_i & bus_gnt_i; dm_gnt_o = sel_d & bus_gnt_i.
  - Data grant → WAIT_D; fetch grant → WAIT_I.
  - No grant → stay in IDLE. The selection is recomputed every cycle, and the requester holds its request.
- In WAIT_I and WAIT_D, bus_req_o = 0 and no grants are issued (single outstanding transaction).
- On bus_rvalid_i in WAIT_D:
  - dm_rvalid_o = 1 and dm_rdata_o = bus_rdata_i in the same cycle (combinational pass-through).
  - Next state is IDLE.
- On bus_rvalid_i in WAIT_I:
  - if_rvalid_o = ~discard & ~if_flush_i; if_rdata_o = bus_rdata_i.
  - Next state is IDLE; discard clears.
- Minimum request-to-request spacing is 2 cycles: grant in cycle N, response earliest N+1, next grant earliest N+2.
- Flush:
  - if_flush_i in the fetch-grant cycle, or at any time in WAIT_I, sets discard. The response is consumed from the bus but if_rvalid_o stays 0.
  - if_flush_i in IDLE without a fetch grant, or in WAIT_D, has no effect.
- Starvation counter:
  - On a data grant with if_req_i = 1: starve_cnt increments, saturating at STARVE_LIMIT.
  - On a fetch grant, or any cycle with if_req_i = 0: starve_cnt clears.
- Simultaneous dm_req_i and if_req_i with starve_cnt = STARVE_LIMIT: fetch is selected.
- bus_rvalid_i in IDLE is a protocol violation. It is ignored, and no rvalid is forwarded.
- Reset mid-transaction → IDLE. A late bus_rvalid_i after reset is ignored per the rule above.
- if_rdata_o and dm_rdata_o are 0 whenever their rvalid is 0.

Test Plan:
- Single fetch: if_req_i = 1, if_addr_i = 0x100, bus_gnt_i = 1, bus_rvalid_i a cycle later with rdata 0x00000013 → if_gnt_o pulse, bus_be_o = 4'hF, if_rvalid_o = 1, if_rdata_o = 0x13; FSM back in IDLE.
- Contention: both requesting continuously, STARVE_LIMIT = 3, 1-cycle memory → grant order D, D, D, I, D, D, D, I; starve_cnt returns to 0 after each I.
- Store: dm_req_i = 1, dm_we_i = 1, dm_be_i = 4'b0011, addr 0x2004, wdata 0xDEADBEEF → bus fields match; dm_rvalid_o on bus_rvalid_i; if_rvalid_o stays 0.
- Flush in flight: fetch granted to 0x200, if_flush_i pulses in WAIT_I, bus_rvalid_i 3 cycles later → if_rvalid_o = 0 throughout; next fetch of 0x300 returns normally.
- Backpressure: bus_gnt_i held 0 for 4 cycles with dm_req_i held → no gnt, FSM stays IDLE, bus_req_o = 1 constant; grant on cycle 5 → WAIT_D.
- Reset mid-op: rst_i in WAIT_D, then bus_rvalid_i the next cycle → dm_rvalid_o = 0, all outputs 0, starve_cnt = 0.
